mdio_phy_responder: RTL and testbench
=====================================

// Module: mdio_phy_responder
// PURPOSE
//  Clause-22 MDIO management responder (PHY side) with a small register set. Samples station-driven MDC/MDIO,
//  decodes read/write frames addressed to PHY_ADDR, returns data on reads and commits writes. Sits opposite
//  the SoC MDIO master: FPGA PHY stand-in and loopback target; BMCR bits drive the MAC clock/loopback muxing.
// PARAMETERS
//  PHY_ADDR      5'd1      PHY address this responder answers to
//  PHY_ID1       16'h0022  value returned for register 2
//  PHY_ID2       16'h1622  value returned for register 3
//  PREAMBLE_LEN  32        consecutive 1s required before ST is accepted (1..32)
// PORTS
//  clock           in   1   system clock; must be >= 8x MDC frequency
//  reset           in   1   asynchronous, active-low reset
//  mdc             in   1   management clock from station (asynchronous to clock)
//  mdio_i          in   1   MDIO pad input
//  mdio_o          out  1   MDIO pad output value
//  mdio_oe         out  1   MDIO output enable (1 = responder drives pad)
//  link_up         in   1   live link status from MAC/PHY logic
//  ctrl_loopback   out  1   BMCR[14]
//  ctrl_speed100   out  1   BMCR[13]
//  ctrl_power_down out  1   BMCR[11]
//  frame_err       out  1   one-cycle pulse: malformed frame (bad ST/OP/write-TA) detected
// BEHAVIOUR
//  Reset (reset=0, async): mdio_oe=0, mdio_o=1, frame_err=0, FSM=PRE, preamble count=0, BMCR=16'h3100
//   (ctrl_loopback=0, ctrl_speed100=1, ctrl_power_down=0), REG31=0, latched link=0.
//  Sync: mdc and mdio_i each pass 2 flops; MDC rising edge detected on the 3rd flop -> "edge". All FSM
//   activity, bit sampling and output updates occur only in the clock cycle of an edge; edge-to-pad latency 3 clocks.
//  FSM (one sampled bit per edge):
//   PRE: bit=1 -> count++ (saturate at PREAMBLE_LEN); bit=0 with count>=PREAMBLE_LEN -> ST1; bit=0 else -> count=0.
//   ST1: bit=1 -> OP (2 bits); bit=0 -> frame_err, PRE, count=0.
//   OP: 10=read, 01=write; 00/11 -> frame_err, PRE, count=0. Then PHYAD (5, MSB first), REGAD (5, MSB first).
//   TA (2 bits): read -> bits ignored; write -> must be 1,0 else frame_err, PRE. Then DATA (16 bits) -> PRE, count=0.
//   PHYAD != PHY_ADDR: frame tracked to completion for alignment, never drives, never writes, no frame_err on TA.
//  Read drive (address match): edge sampling TA bit1 -> mdio_oe=1, mdio_o=0; edge sampling TA bit2 -> mdio_o=D[15];
//   edge sampling D[k] -> mdio_o=D[k-1]; edge sampling D[0] -> mdio_oe=0, mdio_o=1. Read data snapshotted at the
//   edge sampling REGAD[0] (later register changes do not alter an in-flight read).
//  Write commit: in the cycle of the edge sampling D[0]; 16-bit value applied per register map below.
//  Register map (others: read 0, write ignored):
//   0 BMCR RW: writable bits 14,13,12,11,10,8; others read 0. Write with bit15=1 -> BMCR:=16'h3100 same cycle, bit15 reads 0.
//   1 BMSR RO: 16'h7809 | (latched_link<<2). latched_link: cleared any cycle link_up=0; after a completed read of
//     reg 1 (edge sampling D[0]) loads link_up. Simultaneous link_up=0 and reload -> 0.
//   2/3 PHY_ID1/PHY_ID2 RO.  31 scratch RW, all 16 bits.
//  PREAMBLE_LEN ones need not immediately precede ST after a completed frame? No: count is cleared at every frame end
//   and every error; each frame requires a fresh full preamble.
//  mdc stopped mid-frame: state held indefinitely (mdio_oe holds). Reset mid-frame: immediate return to reset values.
//  frame_err and write commit never coincide; frame_err asserts in the edge cycle only.
// TESTING
//  32x1, 01, 10, PHYAD=1, REG=2 -> TA Z then 0, data 0x0022 MSB-first on mdio_o; mdio_oe drops after 16th bit.
//  Write REG31=0xA5C3 then read REG31 -> 0xA5C3; write REG0=0x4000 -> ctrl_loopback=1, ctrl_speed100=0.
//  Write REG0=0x8000 after above -> BMCR reads 0x3100, ctrl_loopback=0, ctrl_speed100=1.
//  link_up 1->0->1 then read REG1 -> 0x7809; second read -> 0x780D.
//  Read to PHYAD=2 -> mdio_oe stays 0 entire frame; next valid frame to PHYAD=1 answered normally.
//  31 ones then ST -> ignored, no frame_err; OP=11 after valid preamble -> frame_err one cycle, no drive.

Source files
------------

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO management responder: synchronises MDC/MDIO, decodes frames addressed
// to PHY_ADDR and serves BMCR, BMSR, PHY ID and a scratch register.
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter logic [15:0] PHY_ID1      = 16'h0022,
    parameter logic [15:0] PHY_ID2      = 16'h1622,
    parameter int unsigned PREAMBLE_LEN = 32
) (
    input  logic clock,
    input  logic reset,
    input  logic mdc,
    input  logic mdio_i,
    output logic mdio_o,
    output logic mdio_oe,
    input  logic link_up,
    output logic ctrl_loopback,
    output logic ctrl_speed100,
    output logic ctrl_power_down,
    output logic frame_err
);
    localparam int unsigned PCW = 6;
    localparam int unsigned BCW = 4;
    localparam int unsigned AW  = 5;
    localparam int unsigned DW  = 16;
    localparam logic [DW-1:0]  BMCR_RST   = 16'h3100;
    localparam logic [DW-1:0]  BMCR_WMASK = 16'h7D00;
    localparam logic [DW-1:0]  BMSR_BASE  = 16'h7809;
    localparam logic [PCW-1:0] PRE_MAX    = PCW'(PREAMBLE_LEN);

    typedef enum logic [2:0] {
        S_PRE, S_ST1, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA
    } state_t;

    state_t         state, state_nxt;
    logic [2:0]     mdc_sync;
    logic [1:0]     mdio_sync;
    logic           mdc_edge, bit_in, addr_match;
    logic [BCW-1:0] cnt, cnt_nxt;
    logic [PCW-1:0] pre_cnt, pre_nxt;
    logic           rd_op, rd_op_nxt;
    logic [AW-1:0]  phyad, phyad_nxt, regad, regad_nxt;
    logic [DW-1:0]  shreg, shreg_nxt;
    logic           mdio_o_nxt, mdio_oe_nxt;
    logic           err_c, wr_c, rd_done_c;
    logic [AW-1:0]  rd_addr_c;
    logic [DW-1:0]  rd_data_c, wr_data_c;
    logic [DW-1:0]  bmcr, scratch;
    logic           link_lat;

    // Two-flop synchronisers; the third MDC flop only serves edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mdc_sync  <= '0;
            mdio_sync <= '1;
        end else begin
            mdc_sync  <= {mdc_sync[1:0], mdc};
            mdio_sync <= {mdio_sync[0], mdio_i};
        end
    end

    assign mdc_edge   = mdc_sync[1] & ~mdc_sync[2];
    assign bit_in     = mdio_sync[1];
    assign addr_match = (phyad == PHY_ADDR);
    assign rd_addr_c  = {regad[AW-2:0], bit_in};
    assign wr_data_c  = {shreg[DW-2:0], bit_in};

    always_comb begin
        rd_data_c = '0;
        case (rd_addr_c)
            5'd0:    rd_data_c = bmcr;
            5'd1:    rd_data_c = BMSR_BASE | {13'd0, link_lat, 2'd0};
            5'd2:    rd_data_c = PHY_ID1;
            5'd3:    rd_data_c = PHY_ID2;
            5'd31:   rd_data_c = scratch;
            default: rd_data_c = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_PRE;
        else        state <= state_nxt;
    end

    // Frame sequencing: one sampled bit per MDC edge.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pre_nxt   = pre_cnt;
        err_c     = 1'b0;
        if (mdc_edge) begin
            cnt_nxt = cnt + BCW'(1);
            case (state)
                S_PRE: begin
                    cnt_nxt = '0;
                    if (bit_in) begin
                        if (pre_cnt < PRE_MAX) pre_nxt = pre_cnt + PCW'(1);
                    end else if (pre_cnt >= PRE_MAX) begin
                        state_nxt = S_ST1;
                    end else begin
                        pre_nxt = '0;
                    end
                end
                S_ST1: begin
                    cnt_nxt = '0;
                    if (bit_in) begin
                        state_nxt = S_OP;
                    end else begin
                        err_c     = 1'b1;
                        state_nxt = S_PRE;
                        pre_nxt   = '0;
                    end
                end
                S_OP: begin
                    if (cnt == BCW'(1)) begin
                        cnt_nxt = '0;
                        if (bit_in == rd_op) begin
                            err_c     = 1'b1;
                            state_nxt = S_PRE;
                            pre_nxt   = '0;
                        end else begin
                            state_nxt = S_PHYAD;
                        end
                    end
                end
                S_PHYAD: begin
                    if (cnt == BCW'(4)) begin
                        cnt_nxt   = '0;
                        state_nxt = S_REGAD;
                    end
                end
                S_REGAD: begin
                    if (cnt == BCW'(4)) begin
                        cnt_nxt   = '0;
                        state_nxt = S_TA;
                    end
                end
                S_TA: begin
                    if (cnt == BCW'(1)) begin
                        cnt_nxt   = '0;
                        state_nxt = S_DATA;
                    end
                    // Write turnaround must be 1 then 0; foreign frames are never flagged.
                    if (!rd_op && addr_match && (bit_in != (cnt == '0))) begin
                        err_c     = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = S_PRE;
                        pre_nxt   = '0;
                    end
                end
                S_DATA: begin
                    if (cnt == BCW'(15)) begin
                        cnt_nxt   = '0;
                        state_nxt = S_PRE;
                        pre_nxt   = '0;
                    end
                end
                default: begin
                    cnt_nxt   = '0;
                    state_nxt = S_PRE;
                    pre_nxt   = '0;
                end
            endcase
        end
    end

    // Field capture, read shifting and pad control.
    always_comb begin
        rd_op_nxt   = rd_op;
        phyad_nxt   = phyad;
        regad_nxt   = regad;
        shreg_nxt   = shreg;
        mdio_o_nxt  = mdio_o;
        mdio_oe_nxt = mdio_oe;
        wr_c        = 1'b0;
        rd_done_c   = 1'b0;
        if (mdc_edge) begin
            case (state)
                S_OP: begin
                    if (cnt == '0) rd_op_nxt = bit_in;
                end
                S_PHYAD: phyad_nxt = {phyad[AW-2:0], bit_in};
                S_REGAD: begin
                    regad_nxt = rd_addr_c;
                    if (cnt == BCW'(4)) shreg_nxt = rd_data_c;
                end
                S_TA: begin
                    if (rd_op && addr_match) begin
                        if (cnt == '0) begin
                            mdio_oe_nxt = 1'b1;
                            mdio_o_nxt  = 1'b0;
                        end else begin
                            mdio_o_nxt = shreg[DW-1];
                            shreg_nxt  = wr_data_c;
                        end
                    end
                end
                S_DATA: begin
                    shreg_nxt = wr_data_c;
                    if (addr_match) begin
                        if (rd_op) begin
                            if (cnt == BCW'(15)) begin
                                mdio_oe_nxt = 1'b0;
                                mdio_o_nxt  = 1'b1;
                                rd_done_c   = (regad == AW'(1));
                            end else begin
                                mdio_o_nxt = shreg[DW-1];
                            end
                        end else if (cnt == BCW'(15)) begin
                            wr_c = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            pre_cnt   <= '0;
            rd_op     <= 1'b0;
            phyad     <= '0;
            regad     <= '0;
            shreg     <= '0;
            mdio_o    <= 1'b1;
            mdio_oe   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            pre_cnt   <= pre_nxt;
            rd_op     <= rd_op_nxt;
            phyad     <= phyad_nxt;
            regad     <= regad_nxt;
            shreg     <= shreg_nxt;
            mdio_o    <= mdio_o_nxt;
            mdio_oe   <= mdio_oe_nxt;
            frame_err <= err_c;
        end
    end

    // Register file; link status latches low until a completed BMSR read.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bmcr     <= BMCR_RST;
            scratch  <= '0;
            link_lat <= 1'b0;
        end else begin
            if (wr_c && regad == AW'(0))
                bmcr <= wr_data_c[DW-1] ? BMCR_RST : (wr_data_c & BMCR_WMASK);
            if (wr_c && regad == AW'(31))
                scratch <= wr_data_c;
            if (!link_up)
                link_lat <= 1'b0;
            else if (rd_done_c)
                link_lat <= 1'b1;
        end
    end

    assign ctrl_loopback   = bmcr[14];
    assign ctrl_speed100   = bmcr[13];
    assign ctrl_power_down = bmcr[11];

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Scoreboard bench for mdio_phy_responder: station-side frame driver, register model,
// and an MDC-sampled monitor that checks every read returned on the pad.
module tb_mdio_phy_responder;
    localparam logic [4:0]  PHY_ADDR = 5'd1;
    localparam logic [15:0] ID1      = 16'h0022;
    localparam logic [15:0] ID2      = 16'h1622;
    localparam int          HALF     = 50;

    logic clock = 1'b0;
    logic reset, mdc, mdio_i, mdio_o, mdio_oe, link_up;
    logic ctrl_loopback, ctrl_speed100, ctrl_power_down, frame_err;
    logic st_oe, st_val;
    int   checks = 0, errors = 0, err_cnt = 0, exp_err = 0;
    logic oe_seen, prev_err, mon_flush;
    logic [15:0] exp_q[$];
    logic [15:0] bmcr_m, scratch_m;
    logic        lat_m;
    int          mon_nbit;
    logic [15:0] mon_got, mon_exp, sval;
    logic [4:0]  regs_pick[6];
    logic [4:0]  rg, phy;

    mdio_phy_responder dut (
        .clock(clock), .reset(reset), .mdc(mdc), .mdio_i(mdio_i),
        .mdio_o(mdio_o), .mdio_oe(mdio_oe), .link_up(link_up),
        .ctrl_loopback(ctrl_loopback), .ctrl_speed100(ctrl_speed100),
        .ctrl_power_down(ctrl_power_down), .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    // Pad with pull-up: responder wins when enabled, else station, else idle high.
    assign mdio_i = mdio_oe ? mdio_o : (st_oe ? st_val : 1'b1);

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        bmcr_m    = 16'h3100;
        scratch_m = 16'h0000;
        lat_m     = 1'b0;
    endfunction

    function automatic logic [15:0] model_read(input logic [4:0] a);
        case (a)
            5'd0:    return bmcr_m;
            5'd1:    return lat_m ? 16'h780D : 16'h7809;
            5'd2:    return ID1;
            5'd3:    return ID2;
            5'd31:   return scratch_m;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic void model_write(input logic [4:0] a, input logic [15:0] d);
        logic [15:0] kept;
        kept = 16'h0000;
        if (a == 5'd0) begin
            if (d[15]) begin
                bmcr_m = 16'h3100;
            end else begin
                kept[14] = d[14]; kept[13] = d[13]; kept[12] = d[12];
                kept[11] = d[11]; kept[10] = d[10]; kept[8]  = d[8];
                bmcr_m = kept;
            end
        end else if (a == 5'd31) begin
            scratch_m = d;
        end
    endfunction

    // frame_err pulse counting and width check
    always @(negedge clock) begin
        if (mdio_oe === 1'b1) oe_seen = 1'b1;
        if (frame_err === 1'b1) begin
            err_cnt++;
            checks++;
            if (prev_err === 1'b1) begin
                errors++;
                $display("FAIL frame_err_width: high 2+ cycles, required 1");
            end
        end
        prev_err = frame_err;
    end

    // Station-side monitor: samples the pad at each MDC rise, like the real master.
    initial begin
        mon_nbit = -1;
        mon_got  = '0;
        forever begin
            @(posedge mdc);
            if (mon_flush) begin
                mon_nbit  = -1;
                exp_q.delete();
                mon_flush = 1'b0;
            end else if (mon_nbit < 0) begin
                if (mdio_oe === 1'b1) begin
                    check("ta_second_bit_zero", 32'(mdio_o), 32'(0));
                    mon_nbit = 0;
                    mon_got  = '0;
                end
            end else if (mon_nbit < 16) begin
                check("oe_during_data", 32'(mdio_oe), 32'(1));
                mon_got  = {mon_got[14:0], mdio_o};
                mon_nbit = mon_nbit + 1;
            end else begin
                check("oe_release_after_d0", 32'(mdio_oe), 32'(0));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read_drive: got 0x%0h, required no drive", mon_got);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("read_data", 32'(mon_got), 32'(mon_exp));
                end
                mon_nbit = -1;
            end
        end
    end

    task automatic send_bit(input logic b, input logic drive);
        st_oe  = drive;
        st_val = b;
        #(HALF) mdc = 1'b1;
        #(HALF) mdc = 1'b0;
    endtask

    task automatic frame(input int npre, input logic [1:0] op, input logic [4:0] fphy,
                         input logic [4:0] frg, input logic [1:0] ta, input logic [15:0] wd,
                         input int ndata);
        logic rd;
        rd = (op == 2'b10);
        for (int i = 0; i < npre; i++) send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(op[1], 1'b1);
        send_bit(op[0], 1'b1);
        if (op == 2'b01 || op == 2'b10) begin
            for (int i = 4; i >= 0; i--) send_bit(fphy[i], 1'b1);
            for (int i = 4; i >= 0; i--) send_bit(frg[i], 1'b1);
            send_bit(ta[1], !rd);
            send_bit(ta[0], !rd);
            for (int i = 0; i < ndata; i++) send_bit(wd[15-i], !rd);
        end
        st_oe  = 1'b1;
        st_val = 1'b1;
    endtask

    task automatic check_ctrl(input string tag);
        check({tag, "_loopback"},   32'(ctrl_loopback),   32'(bmcr_m[14]));
        check({tag, "_speed100"},   32'(ctrl_speed100),   32'(bmcr_m[13]));
        check({tag, "_power_down"}, 32'(ctrl_power_down), 32'(bmcr_m[11]));
    endtask

    task automatic do_read(input logic [4:0] p, input logic [4:0] r);
        if (p == PHY_ADDR) exp_q.push_back(model_read(r));
        oe_seen = 1'b0;
        frame(32 + int'($urandom_range(0, 2)), 2'b10, p, r, 2'b00, 16'h0000, 16);
        if (p == PHY_ADDR) begin
            if (r == 5'd1) lat_m = link_up;
        end else begin
            check("foreign_read_no_drive", 32'(oe_seen), 32'(0));
        end
        check("read_err_count", 32'(err_cnt), 32'(exp_err));
    endtask

    task automatic do_write(input logic [4:0] p, input logic [4:0] r, input logic [15:0] d,
                            input logic [1:0] ta);
        oe_seen = 1'b0;
        frame(32 + int'($urandom_range(0, 2)), 2'b01, p, r, ta, d, 16);
        if (p == PHY_ADDR) begin
            if (ta == 2'b10) model_write(r, d);
            else exp_err++;
        end
        check("write_err_count", 32'(err_cnt), 32'(exp_err));
        check("write_no_drive", 32'(oe_seen), 32'(0));
        if (r == 5'd0) check_ctrl("bmcr");
    endtask

    task automatic set_link(input logic v);
        link_up = v;
        if (!v) lat_m = 1'b0;
        #100;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, required self-termination");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; mdc = 1'b0; st_oe = 1'b1; st_val = 1'b1; link_up = 1'b1;
        oe_seen = 1'b0; prev_err = 1'b0; mon_flush = 1'b0;
        regs_pick = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd31, 5'd9};
        model_reset();
        #102;
        check("reset_mdio_oe", 32'(mdio_oe), 32'(0));
        check("reset_mdio_o", 32'(mdio_o), 32'(1));
        check("reset_frame_err", 32'(frame_err), 32'(0));
        check_ctrl("reset");
        reset = 1'b1;
        #100;

        do_read(PHY_ADDR, 5'd2);
        do_write(PHY_ADDR, 5'd31, 16'hA5C3, 2'b10);
        do_read(PHY_ADDR, 5'd31);
        do_write(PHY_ADDR, 5'd0, 16'h4000, 2'b10);
        do_read(PHY_ADDR, 5'd0);
        do_write(PHY_ADDR, 5'd0, 16'h8000, 2'b10);
        do_read(PHY_ADDR, 5'd0);

        set_link(1'b1); set_link(1'b0); set_link(1'b1);
        do_read(PHY_ADDR, 5'd1);
        do_read(PHY_ADDR, 5'd1);

        do_read(5'd2, 5'd2);
        do_read(PHY_ADDR, 5'd3);

        oe_seen = 1'b0;
        frame(31, 2'b10, PHY_ADDR, 5'd2, 2'b00, 16'h0000, 16);
        check("short_preamble_no_drive", 32'(oe_seen), 32'(0));
        check("short_preamble_no_err", 32'(err_cnt), 32'(exp_err));

        oe_seen = 1'b0;
        frame(32, 2'b11, PHY_ADDR, 5'd2, 2'b00, 16'h0000, 0);
        exp_err++;
        check("op11_frame_err", 32'(err_cnt), 32'(exp_err));
        check("op11_no_drive", 32'(oe_seen), 32'(0));
        frame(32, 2'b00, PHY_ADDR, 5'd2, 2'b00, 16'h0000, 0);
        exp_err++;
        check("op00_frame_err", 32'(err_cnt), 32'(exp_err));

        do_write(PHY_ADDR, 5'd31, 16'hFFFF, 2'b11);
        do_write(PHY_ADDR, 5'd31, 16'hFFFF, 2'b00);
        do_write(5'd7, 5'd31, 16'hFFFF, 2'b00);
        do_read(PHY_ADDR, 5'd31);
        do_write(PHY_ADDR, 5'd5, 16'h1234, 2'b10);
        do_read(PHY_ADDR, 5'd5);

        for (int n = 0; n < 25; n++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            rg  = regs_pick[$urandom_range(0, 5)];
            if ($urandom_range(0, 4) == 0) phy = 5'($urandom_range(0, 31));
            else phy = PHY_ADDR;
            if (sel < 2)      set_link(~link_up);
            else if (sel < 6) do_write(phy, rg, 16'($urandom), 2'b10);
            else              do_read(phy, rg);
        end
        set_link(1'b1);

        sval = 16'($urandom);
        do_write(PHY_ADDR, 5'd31, sval, 2'b10);
        exp_q.push_back(model_read(5'd31));
        frame(32, 2'b10, PHY_ADDR, 5'd31, 2'b00, 16'h0000, 5);
        #400;
        check("mdc_stop_oe_hold", 32'(mdio_oe), 32'(1));
        check("mdc_stop_bit_hold", 32'(mdio_o), 32'(sval[10]));
        reset = 1'b0;
        #1;
        check("midframe_reset_oe", 32'(mdio_oe), 32'(0));
        check("midframe_reset_o", 32'(mdio_o), 32'(1));
        model_reset();
        check_ctrl("midframe_reset");
        #19;
        reset = 1'b1;
        mon_flush = 1'b1;
        #80;
        send_bit(1'b1, 1'b1);
        do_read(PHY_ADDR, 5'd31);
        do_read(PHY_ADDR, 5'd0);

        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        check("pending_reads", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
